// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a host and the UART transmitter.
//   tx_data  : byte offered by the host
//   tx_valid : host offers tx_data this cycle
//   tx_ready : transmitter holding register is empty
// Modports: master (host side), slave (transmitter side).
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 (8N2) UART serial transmitter with a one-byte holding register.
// Bytes are accepted over a valid/ready handshake and shifted out LSB-first,
// 16 ticks of uart_tick_16x per bit. Back-to-back frames carry no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// (8E1 / 8E2 frames).
//
// Ports:
//   clock         : system clock, all state updates on posedge
//   reset_n       : asynchronous active-low reset
//   uart_tick_16x : single-cycle enable at 16x the baud rate
//   tx_bus        : uart_tx_if.slave (tx_data, tx_valid in; tx_ready out)
//   TxD           : serial line, idles high, driven from a flop
//   busy          : high whenever a frame is on the line
module uart_tx #(
    parameter int unsigned STOP_BITS = 1
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     uart_tick_16x,
    uart_tx_if.slave tx_bus,
    output logic     TxD,
    output logic     busy
);

    if (!(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e     r_state, w_state_next;
    logic [7:0] r_hold_data;
    logic       r_hold_full, w_hold_full_next;
    logic [7:0] r_shift, w_shift_next;
    logic [3:0] r_tick_cnt, w_tick_cnt_next;
    logic [2:0] r_bit_idx, w_bit_idx_next;
    logic       r_stop_cnt, w_stop_cnt_next;
    logic       r_txd, w_txd_next;
    logic       w_accept;
    logic       w_load;
`ifdef UART_TX_PARITY_EN
    logic       r_parity, w_parity_next;
`endif

    assign w_accept        = tx_bus.tx_valid & ~r_hold_full;
    assign tx_bus.tx_ready = ~r_hold_full;
    assign TxD             = r_txd;
    assign busy            = (r_state != StIdle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_hold_data <= 8'h00;
            r_hold_full <= 1'b0;
            r_shift     <= 8'h00;
            r_tick_cnt  <= 4'd0;
            r_bit_idx   <= 3'd0;
            r_stop_cnt  <= 1'b0;
            r_txd       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_hold_full <= w_hold_full_next;
            r_shift     <= w_shift_next;
            r_tick_cnt  <= w_tick_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_stop_cnt  <= w_stop_cnt_next;
            r_txd       <= w_txd_next;
`ifdef UART_TX_PARITY_EN
            r_parity    <= w_parity_next;
`endif
            if (w_accept) begin
                r_hold_data <= tx_bus.tx_data;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_txd_next      = r_txd;
        w_load          = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next   = r_parity;
`endif

        if (uart_tick_16x) begin
            // Counter wraps 15 -> 0 on its own, so each bit is exactly 16 ticks.
            if (r_state != StIdle) begin
                w_tick_cnt_next = r_tick_cnt + 4'd1;
            end

            unique case (r_state)
                StIdle: begin
                    if (r_hold_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_txd_next = 1'b1;
                    end
                end
                StStart: begin
                    if (r_tick_cnt == 4'd15) begin
                        w_state_next   = StData;
                        w_bit_idx_next = 3'd0;
                        w_txd_next     = r_shift[0];
                    end
                end
                StData: begin
                    if (r_tick_cnt == 4'd15) begin
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = StParity;
                            w_txd_next   = r_parity;
`else
                            w_state_next    = StStop;
                            w_stop_cnt_next = 1'b0;
                            w_txd_next      = 1'b1;
`endif
                        end else begin
                            // Next data bit is the one about to shift into bit 0.
                            w_txd_next = r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (r_tick_cnt == 4'd15) begin
                        w_state_next    = StStop;
                        w_stop_cnt_next = 1'b0;
                        w_txd_next      = 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (r_tick_cnt == 4'd15) begin
                        if (STOP_BITS == 2 && !r_stop_cnt) begin
                            w_stop_cnt_next = 1'b1;
                        end else if (r_hold_full) begin
                            // Chain straight into the next start bit.
                            w_load = 1'b1;
                        end else begin
                            w_state_next = StIdle;
                            w_txd_next   = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = StIdle;
                    w_txd_next   = 1'b1;
                end
            endcase

            if (w_load) begin
                w_state_next    = StStart;
                w_shift_next    = r_hold_data;
                w_tick_cnt_next = 4'd0;
                w_txd_next      = 1'b0;
`ifdef UART_TX_PARITY_EN
                w_parity_next   = ^r_hold_data;
`endif
            end
        end
    end

    // Accept needs an empty holder and load needs a full one, so they never collide.
    always_comb begin
        w_hold_full_next = r_hold_full;
        if (w_load) begin
            w_hold_full_next = 1'b0;
        end else if (w_accept) begin
            w_hold_full_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// A free-running monitor compares TxD, busy and tx_ready every clock against a
// queue-based line model; directed table vectors and hand-written sequences
// check frame shape, back-to-back streaming, backpressure and mid-frame reset.
module tb_uart_tx;

    localparam int unsigned STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 10 + STOP_BITS;
`else
    localparam int NB = 9 + STOP_BITS;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic uart_tick_16x = 1'b0;
    logic TxD;
    logic busy;

    uart_tx_if tx_if ();

    uart_tx #(
        .STOP_BITS(STOP_BITS)
    ) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .uart_tick_16x(uart_tick_16x),
        .tx_bus       (tx_if),
        .TxD          (TxD),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Tick every third clock, changed on negedge.
    initial begin
        int c = 0;
        forever begin
            @(negedge clock);
            c = (c == 2) ? 0 : c + 1;
            uart_tick_16x = (c == 0);
        end
    end

    // Reference line model: a frame becomes 16 samples per bit in a queue.
    bit         q_line[$];
    logic [7:0] pend[$];
    logic       m_txd = 1'b1;
    logic       m_busy = 1'b0;
    logic       cap_tick = 1'b0;
    logic       cap_acc = 1'b0;
    logic [7:0] cap_data = 8'h00;

    function automatic void push_frame(input logic [7:0] d);
        bit b;
        for (int k = 0; k < NB; k++) begin
            if (k == 0) b = 1'b0;
            else if (k <= 8) b = d[k-1];
`ifdef UART_TX_PARITY_EN
            else if (k == 9) b = ^d;
`endif
            else b = 1'b1;
            for (int i = 0; i < 16; i++) q_line.push_back(b);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                q_line.delete();
                pend.delete();
                m_txd  = 1'b1;
                m_busy = 1'b0;
            end else begin
                if (cap_tick) begin
                    if (q_line.size() == 0 && pend.size() != 0) push_frame(pend.pop_front());
                    if (q_line.size() != 0) begin
                        m_txd  = q_line.pop_front();
                        m_busy = 1'b1;
                    end else begin
                        m_txd  = 1'b1;
                        m_busy = 1'b0;
                    end
                end
                if (cap_acc) pend.push_back(cap_data);
            end
            #1;
            check("mon_txd", 32'(TxD), 32'(m_txd));
            check("mon_busy", 32'(busy), 32'(m_busy));
            check("mon_ready", 32'(tx_if.tx_ready), 32'(pend.size() == 0));
            @(negedge clock);
            #2;
            cap_tick = uart_tick_16x;
            cap_acc  = reset_n && tx_if.tx_valid && (pend.size() == 0);
            cap_data = tx_if.tx_data;
        end
    end

    task automatic wait_tick();
        do begin
            @(posedge clock);
        end while (!uart_tick_16x);
        #1;
    endtask

    // Offer a byte (optionally wiggling data while not ready); returns accepted byte.
    task automatic send(input logic [7:0] d, input bit wiggle, output logic [7:0] got);
        int n = 0;
        @(negedge clock);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        while (!tx_if.tx_ready && n < 3000) begin
            @(negedge clock);
            if (wiggle) tx_if.tx_data = 8'($urandom);
            n++;
        end
        check("send_ready_timeout", 32'(tx_if.tx_ready), 32'd1);
        got = tx_if.tx_data;
        @(posedge clock);
        #1;
        tx_if.tx_valid = 1'b0;
    endtask

    function automatic logic [10:0] bits_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic check_frame(input logic [10:0] bits, input string name);
        for (int b = 0; b < NB; b++) begin
            int good = 0;
            for (int i = 0; i < 16; i++) begin
                wait_tick();
                if (TxD === bits[b] && busy === 1'b1) good++;
            end
            check($sformatf("%s bit%0d good samples", name, b), 32'(good), 32'd16);
        end
    endtask

    task automatic check_idle(input string name);
        wait_tick();
        check({name, " idle TxD"}, 32'(TxD), 32'd1);
        check({name, " idle busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;  // start, 8 data bits, stop; bit k is frame bit k
        logic       par;
    } vec_t;

    function automatic logic [10:0] tbl_bits(input vec_t e);
`ifdef UART_TX_PARITY_EN
        return {1'b1, e.par, e.line[8:0]};
`else
        return {1'b0, e.line};
`endif
    endfunction

    initial begin
        vec_t       tbl[8];
        logic [7:0] got;
        logic [7:0] got2;

        tbl[0] = '{data: 8'h55, line: 10'h2AA, par: 1'b0};
        tbl[1] = '{data: 8'h07, line: 10'h20E, par: 1'b1};
        tbl[2] = '{data: 8'h03, line: 10'h206, par: 1'b0};
        tbl[3] = '{data: 8'h00, line: 10'h200, par: 1'b0};
        tbl[4] = '{data: 8'hFF, line: 10'h3FE, par: 1'b0};
        tbl[5] = '{data: 8'h80, line: 10'h300, par: 1'b1};
        tbl[6] = '{data: 8'h01, line: 10'h202, par: 1'b1};
        tbl[7] = '{data: 8'hA3, line: 10'h346, par: 1'b0};

        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;

        // Reset held for 5 clocks with the tick running.
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("rst TxD", 32'(TxD), 32'd1);
            check("rst ready", 32'(tx_if.tx_ready), 32'd1);
            check("rst busy", 32'(busy), 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) check_idle("post_reset");

        // Table vectors, one frame each from an idle line.
        for (int v = 0; v < 8; v++) begin
            send(tbl[v].data, 1'b0, got);
            check_frame(tbl_bits(tbl[v]), $sformatf("tbl%0d", v));
            check_idle($sformatf("tbl%0d", v));
        end

        // Back-to-back: second byte offered as soon as tx_ready rises.
        send(8'hA3, 1'b0, got);
        fork
            send(8'h0F, 1'b0, got2);
            begin
                check_frame(tbl_bits(tbl[7]), "b2b_first");
                check_frame(tbl_bits('{data: 8'h0F, line: 10'h21E, par: 1'b0}), "b2b_second");
                check_idle("b2b");
            end
        join

        // Backpressure: data changes every cycle while not ready.
        send(8'h3C, 1'b0, got);
        fork
            begin
                send(8'($urandom), 1'b1, got2);
                tx_if.tx_valid = 1'b1;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clock);
                    tx_if.tx_data = 8'($urandom);
                end
                tx_if.tx_valid = 1'b0;
            end
            begin
                check_frame(bits_of(8'h3C), "bp_first");
                check_frame(bits_of(got2), "bp_second");
                check_idle("bp");
            end
        join

        // Mid-frame reset during data bit 4 of 0x00, with 0xFF waiting in the holder.
        send(8'h00, 1'b0, got);
        fork
            send(8'hFF, 1'b0, got2);
            repeat (89) wait_tick();
        join
        check("mrst pre TxD", 32'(TxD), 32'd0);
        check("mrst pre busy", 32'(busy), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mrst TxD", 32'(TxD), 32'd1);
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst ready", 32'(tx_if.tx_ready), 32'd1);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) check_idle("mrst_after");

        // Randomised stream against the line model.
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 600)) @(negedge clock);
            send(8'($urandom), 1'b1, got);
        end
        begin
            int n = 0;
            while ((busy || q_line.size() != 0 || pend.size() != 0) && n < 5000) begin
                @(posedge clock);
                n++;
            end
            check("drain busy", 32'(busy), 32'd0);
        end

        repeat (5) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
